// File: rtl/sr_pkg.sv
// Shared types and constants for the SR latch driver: FSM state encoding,
// command opcodes and the width of the reusable pulse timer.
package sr_pkg;

  localparam int CNT_W = 8;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RELEASE,
    ST_CHECK
  } state_t;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command handshake plus latch drive/readback bundle between control logic
// (master) and the SR latch driver (slave).
interface sr_latch_driver_if;

  logic cmd_valid;
  logic cmd_op;
  logic cmd_ready;
  logic s;
  logic r;
  logic q_in;
  logic qb_in;
  logic done;
  logic err;
  logic q_last;

  modport master (
    output cmd_valid, cmd_op, q_in, qb_in,
    input  cmd_ready, s, r, done, err, q_last
  );

  modport slave (
    input  cmd_valid, cmd_op, q_in, qb_in,
    output cmd_ready, s, r, done, err, q_last
  );

endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that sticks at zero; zero marks the final cycle of
// whichever timed phase loaded it.
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked front-end for a NOR SR latch: one-sided S/R pulse, dead time, then
// q/qb readback with timeout. S and R are never high together.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned DEAD_W  = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_driver_if.slave   bus
);

  // Timer holds "cycles remaining after this one", so each phase loads W-1.
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEAD_W - 1);
  localparam logic [CNT_W-1:0] TOUT_LD  = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             op_q;
  logic             s_q;
  logic             r_q;
  logic             done_q;
  logic             err_q;
  logic             q_last_q;
  logic             accept;
  logic             match;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  assign bus.cmd_ready = (state == ST_IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  // q==qb (both 0 or both 1) can never satisfy this, so it counts as a mismatch.
  assign match         = (bus.q_in == op_q) && (bus.qb_in == !op_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        tmr_load = accept;
        tmr_val  = PULSE_LD;
      end
      ST_DRIVE: begin
        tmr_load = tmr_zero;
        tmr_dec  = !tmr_zero;
        tmr_val  = DEAD_LD;
      end
      ST_RELEASE: begin
        tmr_load = tmr_zero;
        tmr_dec  = !tmr_zero;
        tmr_val  = TOUT_LD;
      end
      ST_CHECK: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_RST;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      q_last_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= bus.cmd_op;
            s_q   <= (bus.cmd_op == OP_SET);
            r_q   <= (bus.cmd_op == OP_RST);
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (tmr_zero) begin
            s_q   <= 1'b0;
            r_q   <= 1'b0;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (tmr_zero) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (match) begin
            done_q   <= 1'b1;
            q_last_q <= op_q;
            state    <= ST_IDLE;
          end else if (tmr_zero) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s      = s_q;
  assign bus.r      = r_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.q_last = q_last_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver closed-loop with a behavioural NOR latch;
// a stuck flag forces q=qb=0 to exercise the timeout path.
module tb_sr_latch_driver;
  import sr_pkg::*;

  localparam int P = 4;
  localparam int D = 2;
  localparam int T = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic stuck = 1'b0;
  logic lq    = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  sr_latch_driver_if bus ();

  sr_latch_driver #(
    .PULSE_W (P),
    .DEAD_W  (D),
    .TIMEOUT (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cross-coupled NOR behaviour: S sets, R clears, neither holds.
  always @(bus.s, bus.r) begin
    if (bus.s && !bus.r)      lq = 1'b1;
    else if (bus.r && !bus.s) lq = 1'b0;
  end

  assign bus.q_in  = stuck ? 1'b0 : lq;
  assign bus.qb_in = stuck ? 1'b0 : ~lq;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a command at the current (idle) negedge; n_done is the number of
  // edges from the accept edge to the edge that registers done.
  task automatic run_cmd(input logic op, input int n_done, input logic exp_err,
                         input logic exp_q_last, input string tag);
    check({tag, "_ready_pre"}, 16'(bus.cmd_ready), 16'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ~op;
    for (int i = 0; i < n_done; i++) begin
      check({tag, "_s"},     16'(bus.s),         16'((op == OP_SET) && (i < P)));
      check({tag, "_r"},     16'(bus.r),         16'((op == OP_RST) && (i < P)));
      check({tag, "_done0"}, 16'(bus.done),      16'd0);
      check({tag, "_busy"},  16'(bus.cmd_ready), 16'd0);
      tick();
    end
    check({tag, "_done"},   16'(bus.done),      16'd1);
    check({tag, "_err"},    16'(bus.err),       16'(exp_err));
    check({tag, "_q_last"}, 16'(bus.q_last),    16'(exp_q_last));
    check({tag, "_ready"},  16'(bus.cmd_ready), 16'd1);
  endtask

  initial begin
    int accepts;
    int dones;
    int cyc;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;

    // Two cycles of reset.
    @(negedge clk);
    tick();
    check("rst_s",     16'(bus.s),         16'd0);
    check("rst_r",     16'(bus.r),         16'd0);
    check("rst_ready", 16'(bus.cmd_ready), 16'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready",  16'(bus.cmd_ready), 16'd1);
    check("post_rst_done",   16'(bus.done),      16'd0);
    check("post_rst_err",    16'(bus.err),       16'd0);
    check("post_rst_q_last", 16'(bus.q_last),    16'd0);
    check("post_rst_sr",     16'({bus.s, bus.r}), 16'd0);

    // Set, then a back-to-back clear on the done cycle: done 8 cycles after accept.
    run_cmd(1'b1, 7, 1'b0, 1'b1, "set");
    run_cmd(1'b0, 7, 1'b0, 1'b0, "clr");

    // Stuck latch (q=qb=0): error after the full timeout, q_last untouched.
    stuck = 1'b1;
    run_cmd(1'b1, 14, 1'b1, 1'b0, "stuck");
    stuck = 1'b0;

    // Latch now holds 1, so the second set is redundant but still fully pulsed.
    run_cmd(1'b1, 7, 1'b0, 1'b1, "set2");
    run_cmd(1'b1, 7, 1'b0, 1'b1, "redundant");

    // Reset two cycles into an S pulse.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("mid_s0", 16'(bus.s), 16'd1);
    tick();
    check("mid_s1", 16'(bus.s), 16'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_s",      16'(bus.s),         16'd0);
    check("mid_rst_r",      16'(bus.r),         16'd0);
    check("mid_rst_done",   16'(bus.done),      16'd0);
    check("mid_rst_q_last", 16'(bus.q_last),    16'd0);
    check("mid_rst_ready",  16'(bus.cmd_ready), 16'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("mid_rst_idle_ready", 16'(bus.cmd_ready), 16'd1);
      check("mid_rst_no_done",    16'(bus.done),      16'd0);
      tick();
    end

    // Random command stream with gaps.
    accepts = 0;
    dones   = 0;
    cyc     = 0;
    while (accepts < 50 && cyc < 5000) begin
      bus.cmd_valid = ($urandom_range(0, 2) == 0);
      bus.cmd_op    = 1'($urandom);
      if (bus.cmd_valid && bus.cmd_ready) accepts++;
      tick();
      cyc++;
      check("rand_overlap", 16'(bus.s & bus.r), 16'd0);
      if (bus.done) begin
        dones++;
        check("rand_err", 16'(bus.err), 16'd0);
      end
    end
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("drain_overlap", 16'(bus.s & bus.r), 16'd0);
      if (bus.done) begin
        dones++;
        check("drain_err", 16'(bus.err), 16'd0);
      end
    end
    check("rand_accepts", 16'(accepts), 16'd50);
    check("rand_dones",   16'(dones),   16'(accepts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
